// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t      : responder FSM encoding (idle / latency wait / response)
//   dmem_req_t   : captured request fields (direction, store data, lanes, error)
//   WORD_W, BE_W : data word width and byte-enable width
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;   // holds LATENCY-2 for LATENCY up to 15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              err;
    } dmem_req_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Contents have no reset.
//   clk_i   : clock
//   en_i    : access strobe (one access per enabled edge)
//   we_i    : 1 = write enabled lanes, 0 = read into rdata_o
//   addr_i  : word index
//   wdata_i : write data
//   be_i    : byte-lane write enables
//   rdata_o : registered read data, updated only by enabled reads
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [WORD_W-1:0] rdata_o
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (be_i[k]) mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end
endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the CPU data port. Accepts one load/store over a
// req/ack handshake and answers exactly LATENCY cycles after acceptance.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   req_i, we_i        : request valid (held until ack), store/load select
//   addr_i             : byte address; word index = addr_i[AW+1:2]
//   wdata_i, be_i      : store data and byte-lane enables
//   ack_o              : one-cycle response strobe
//   rdata_o            : load data while ack_o on a load, else 0
//   err_o              : address error, qualified by ack_o
// Optional feature: define DMEM_ADDR_CHECK_EN to flag misaligned or
// out-of-range addresses; flagged requests ack with err_o=1, write nothing
// and return zero. Without it err_o is 0 and addresses wrap.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dmem_req_t         req_q, req_cur, sel;
    logic [AW-1:0]     widx_q, widx_sel;
    logic              addr_err;
    logic              accept, commit;
    logic [WORD_W-1:0] ram_rdata;

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_err = (addr_i[1:0] != 2'b00) || (addr_i[WORD_W-1:AW+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[WORD_W-1:AW+2], addr_i[1:0]};
    assign addr_err = 1'b0;
`endif

    assign req_cur = '{we: we_i, wdata: wdata_i, be: be_i, err: addr_err};
    assign accept  = (state_q == ST_IDLE) && req_i && !rst_i;

    // The RAM access happens on the edge that enters RESP. With LATENCY==1
    // that is the acceptance edge itself, so in IDLE the RAM is driven
    // straight from the ports rather than from the capture registers.
    assign sel      = (state_q == ST_IDLE) ? req_cur : req_q;
    assign widx_sel = (state_q == ST_IDLE) ? addr_i[AW+1:2] : widx_q;
    assign commit   = (accept && (LATENCY == 1)) ||
                      ((state_q == ST_WAIT) && (cnt_q == '0) && !rst_i);

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk_i   (clk_i),
        .en_i    (commit),
        .we_i    (sel.we && !sel.err),
        .addr_i  (widx_sel),
        .wdata_i (sel.wdata),
        .be_i    (sel.be),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q  <= req_cur;
                widx_q <= addr_i[AW+1:2];
            end
        end
    end

    assign ack_o   = (state_q == ST_RESP);
    assign rdata_o = (ack_o && !req_q.we && !req_q.err) ? ram_rdata : '0;
    assign err_o   = ack_o && req_q.err;
endmodule
